// File: rtl/vote_pkg.sv
// Shared constants for the voter datapath: switch count, width of the
// yes-vote count, and the default debounce window. The downstream voter
// and display stages import the same package, so all three stay in step.
//
// Contents:
//   NUM_SW                  number of voter switches
//   YES_W                   width of a vote count (holds 0..NUM_SW)
//   DEBOUNCE_CYCLES_DEFAULT default stable-cycle window (1 ms at 50 MHz)
//   cnt_width()             width of a debounce/startup counter
//   popcount()              number of ones in a switch vector
package vote_pkg;

  localparam int NUM_SW                  = 5;
  localparam int YES_W                   = 3;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

  // The +3 leaves headroom above the terminal count so a saturating
  // counter can never wrap back into the live range.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 3);
  endfunction

  function automatic logic [YES_W-1:0] popcount(input logic [NUM_SW-1:0] v);
    logic [YES_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      n = n + YES_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// Single-bit switch debouncer: two-flop synchronizer followed by a
// stable-level counter.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   run        synchronized reset release; counting is held off until high
//   sw_raw     raw asynchronous switch input
//   clean_next value sw_clean will take on the next edge
//   sw_clean   debounced level
//
// The counter advances each cycle the synchronized level differs from the
// debounced level and clears whenever they agree, so any excursion shorter
// than DEBOUNCE_CYCLES cycles is discarded. When the counter sits at
// DEBOUNCE_CYCLES-1 and the levels still differ, the new level is accepted
// and the counter clears on the same edge.
module debounce_chan
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic sw_raw,
  output logic clean_next,
  output logic sw_clean
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             clean_q, clean_d;

  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (run) begin
      if (sync2_q != clean_q) begin
        if (cnt_q == CNT_LAST) begin
          clean_d = sync2_q;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean_next = clean_d;
  assign sw_clean   = clean_q;

endmodule

// File: rtl/sw_debounce.sv
// Debounces the NUM_SW voter switches and produces the clean switch
// vector, its yes-vote count, a change pulse and a startup-valid flag.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   sw         raw bouncing switches
//   sw_clean   debounced switch levels (feed to the majority voter)
//   sw_valid   high once the startup settle window has elapsed
//   chg_pulse  one-cycle pulse in the cycle sw_clean takes a new value
//   yes_count  popcount of sw_clean, aligned with sw_clean
//
// Outputs derived from sw_clean are computed from each channel's next
// value so that they change on the same edge as sw_clean itself.
module sw_debounce
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] sw,
  output logic [NUM_SW-1:0] sw_clean,
  output logic              sw_valid,
  output logic              chg_pulse,
  output logic [YES_W-1:0]  yes_count
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Reset is asserted asynchronously but released through two flops so
  // every counter leaves reset on the same, clean edge.
  logic rst_sync1_q, rst_sync1_d;
  logic rst_sync2_q, rst_sync2_d;
  logic run;

  logic [NUM_SW-1:0] clean_next;

  logic [CNT_W-1:0] st_cnt_q, st_cnt_d;
  logic             valid_q,  valid_d;
  logic             chg_q,    chg_d;
  logic [YES_W-1:0] yes_q,    yes_d;

  assign rst_sync1_d = 1'b1;
  assign rst_sync2_d = rst_sync1_q;
  assign run         = rst_sync2_q;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .sw_raw    (sw[i]),
      .clean_next(clean_next[i]),
      .sw_clean  (sw_clean[i])
    );
  end

  // Startup window uses the same terminal count as a channel, so a switch
  // held since reset release is accepted on the very edge sw_valid rises.
  always_comb begin
    st_cnt_d = st_cnt_q;
    valid_d  = valid_q;
    if (run && !valid_q) begin
      if (st_cnt_q == CNT_LAST) begin
        valid_d = 1'b1;
      end else if (st_cnt_q != CNT_MAX) begin
        st_cnt_d = st_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    chg_d = valid_d && (clean_next != sw_clean);
    yes_d = popcount(clean_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync1_q <= 1'b0;
      rst_sync2_q <= 1'b0;
      st_cnt_q    <= '0;
      valid_q     <= 1'b0;
      chg_q       <= 1'b0;
      yes_q       <= '0;
    end else begin
      rst_sync1_q <= rst_sync1_d;
      rst_sync2_q <= rst_sync2_d;
      st_cnt_q    <= st_cnt_d;
      valid_q     <= valid_d;
      chg_q       <= chg_d;
      yes_q       <= yes_d;
    end
  end

  assign sw_valid  = valid_q;
  assign chg_pulse = chg_q;
  assign yes_count = yes_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES = 4.
// Expected output words {sw_clean, yes_count, chg_pulse, sw_valid} are
// pushed when stimulus is driven and popped when the edge has been taken.
module tb_sw_debounce;

  localparam int DC = 4;

  logic       clk;
  logic       rst_n;
  logic [4:0] sw;
  logic [4:0] sw_clean;
  logic       sw_valid;
  logic       chg_pulse;
  logic [2:0] yes_count;

  int checks;
  int errors;

  logic [9:0] exp_q[$];
  logic [9:0] msk_q[$];

  localparam logic [9:0] ALL    = 10'h3ff;
  localparam logic [9:0] NO_CHG = 10'h3fd;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .sw_clean (sw_clean),
    .sw_valid (sw_valid),
    .chg_pulse(chg_pulse),
    .yes_count(yes_count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] pk(input logic [4:0] c, input logic [2:0] y,
                                    input logic ch, input logic v);
    return {c, y, ch, v};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] e, input logic [9:0] m);
    exp_q.push_back(e);
    msk_q.push_back(m);
  endtask

  // scoreboard
  task automatic check(input string tag);
    logic [9:0] e, m, o;
    o = {sw_clean, yes_count, chg_pulse, sw_valid};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, o);
    end else begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      assert ((o & m) === (e & m)) else begin
        errors++;
        $error("FAIL %s: observed clean=%b yes=%0d chg=%b valid=%b expected clean=%b yes=%0d chg=%b valid=%b",
               tag, o[9:5], o[4:2], o[1], o[0], e[9:5], e[4:2], e[1], e[0]);
      end
    end
  endtask

  task automatic step(input logic [9:0] e, input logic [9:0] m, input string tag);
    push(e, m);
    tick();
    check(tag);
  endtask

  // Settle from clean value `from` to `to` with sw driven to `to` now:
  // the update lands on edge DC+2 with a single pulse.
  task automatic settle(input logic [4:0] from, input logic [4:0] to, input string tag);
    logic [4:0] c;
    logic [2:0] y_from, y_to;
    y_from = 3'($countones(from));
    y_to   = 3'($countones(to));
    sw = to;
    for (int e = 1; e <= DC + 4; e++) begin
      c = (e >= DC + 2) ? to : from;
      step(pk(c, (e >= DC + 2) ? y_to : y_from, e == DC + 2, 1'b1), ALL,
           $sformatf("%s_e%0d", tag, e));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    sw     = 5'b00000;

    // reset held
    #3;
    push(pk(5'b0, 3'd0, 1'b0, 1'b0), ALL);
    check("reset_hold");
    tick();
    tick();
    push(pk(5'b0, 3'd0, 1'b0, 1'b0), ALL);
    check("reset_hold_edges");

    // startup: sw_valid rises on edge DC+2 after release
    rst_n = 1'b1;
    for (int e = 1; e <= DC + 4; e++) begin
      step(pk(5'b0, 3'd0, 1'b0, e >= DC + 2), ALL, $sformatf("startup_e%0d", e));
    end

    // staggered rises: sw[0], then sw[3] two cycles later
    sw = 5'b00001;
    for (int e = 1; e <= DC + 6; e++) begin
      if (e == 3) sw = 5'b01001;
      if (e >= DC + 4)
        step(pk(5'b01001, 3'd2, e == DC + 4, 1'b1), ALL, $sformatf("stagger_e%0d", e));
      else if (e >= DC + 2)
        step(pk(5'b00001, 3'd1, e == DC + 2, 1'b1), ALL, $sformatf("stagger_e%0d", e));
      else
        step(pk(5'b00000, 3'd0, 1'b0, 1'b1), ALL, $sformatf("stagger_e%0d", e));
    end
    settle(5'b01001, 5'b00000, "stagger_fall");

    // three switches together
    settle(5'b00000, 5'b00111, "rise3");

    // short glitches on sw[4]: three cycles high, three low, five times
    for (int r = 0; r < 5; r++) begin
      sw = 5'b10111;
      for (int h = 0; h < DC - 1; h++)
        step(pk(5'b00111, 3'd3, 1'b0, 1'b1), ALL, $sformatf("glitch_r%0d_h%0d", r, h));
      sw = 5'b00111;
      for (int l = 0; l < 3; l++)
        step(pk(5'b00111, 3'd3, 1'b0, 1'b1), ALL, $sformatf("glitch_r%0d_l%0d", r, l));
    end
    for (int l = 0; l < 4; l++)
      step(pk(5'b00111, 3'd3, 1'b0, 1'b1), ALL, $sformatf("glitch_tail_%0d", l));
    settle(5'b00111, 5'b00000, "fall3");

    // all five together
    settle(5'b00000, 5'b11111, "rise5");
    settle(5'b11111, 5'b00000, "fall5");

    // reset while sw[1] is mid-count
    sw = 5'b00010;
    for (int e = 1; e <= 4; e++) begin
      step(pk(5'b0, 3'd0, 1'b0, 1'b1), ALL, $sformatf("midcount_e%0d", e));
    end
    rst_n = 1'b0;
    #2;
    push(pk(5'b0, 3'd0, 1'b0, 1'b0), ALL);
    check("reset_async");
    tick();
    push(pk(5'b0, 3'd0, 1'b0, 1'b0), ALL);
    check("reset_mid_hold");
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= DC + 4; e++) begin
      if (e == DC + 2)
        step(pk(5'b00010, 3'd1, 1'b0, 1'b1), NO_CHG, $sformatf("rerelease_e%0d", e));
      else if (e > DC + 2)
        step(pk(5'b00010, 3'd1, 1'b0, 1'b1), ALL, $sformatf("rerelease_e%0d", e));
      else
        step(pk(5'b0, 3'd0, 1'b0, 1'b0), ALL, $sformatf("rerelease_e%0d", e));
    end

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
